// File: rtl/lwdo_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lwdo_regs_pkg
// Description : Register indices and constants for the LWDO register block.
// Revision    : 1.0 - initial release
// ============================================================================
package lwdo_regs_pkg;

    localparam int unsigned REG_MAGIC   = 0;
    localparam int unsigned REG_CON     = 1;
    localparam int unsigned REG_ADCSTR1 = 2;
    localparam int unsigned REG_ADCSTR2 = 3;

    localparam logic [31:0] MAGIC_VALUE = 32'h4C57444F;  // "LWDO"
    localparam int unsigned CON_RST_BIT = 0;

endpackage : lwdo_regs_pkg
`default_nettype wire

// File: rtl/wb_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_slave_if
// Description : Pipelined Wishbone slave front end: accept decode and
//               single-cycle-latency ack generation. Never stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_slave_if #(
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wb_cyc,
    input  logic                     i_wb_stb,
    input  logic                     i_wb_we,
    input  logic [ADDRESS_WIDTH-1:2] i_wb_word_adr,
    output logic                     o_wb_stall,
    output logic                     o_wb_ack,
    output logic                     o_rd_accept,
    output logic                     o_wr_accept,
    output logic [ADDRESS_WIDTH-3:0] o_index
);

    logic w_accept;
    logic r_ack;

    assign o_wb_stall = 1'b0;

    // Requests seen while reset is asserted are dropped outright.
    assign w_accept    = i_wb_cyc & i_wb_stb & ~o_wb_stall & ~i_rst;
    assign o_rd_accept = w_accept & ~i_wb_we;
    assign o_wr_accept = w_accept &  i_wb_we;
    assign o_index     = i_wb_word_adr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= w_accept;
        end
    end

    assign o_wb_ack = r_ack;

endmodule : wb_slave_if
`default_nettype wire

// File: rtl/lwdo_regs_wb.sv
`default_nettype none
// ============================================================================
// Module      : lwdo_regs_wb
// Description : LWDO Wishbone register slave: magic ID, control register and
//               read-to-pop ports for the two ADC stream FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
module lwdo_regs_wb
    import lwdo_regs_pkg::*;
#(
    parameter int          ADDRESS_WIDTH     = 10,
    parameter logic [31:0] DEFAULT_READ_DATA = 32'h00000000
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wb_cyc,
    input  logic                     i_wb_stb,
    output logic                     o_wb_stall,
    output logic                     o_wb_ack,
    input  logic                     i_wb_we,
    input  logic [ADDRESS_WIDTH-1:0] i_wb_adr,
    input  logic [31:0]              i_wb_dat,
    input  logic [3:0]               i_wb_sel,
    output logic [31:0]              o_wb_dat,
    input  logic [31:0]              i_adcstr1_rx_data,
    input  logic [31:0]              i_adcstr2_rx_data,
    output logic                     o_adcstr1_rx_data_read_trigger,
    output logic                     o_adcstr2_rx_data_read_trigger,
    output logic                     o_con_rst
);

    localparam int IW = ADDRESS_WIDTH - 2;

    logic          w_rd_accept;
    logic          w_wr_accept;
    logic [IW-1:0] w_index;
    logic [31:0]   w_rd_data;
    logic          w_unused;
    logic          r_con_rst;
    logic [31:0]   r_dat;

    wb_slave_if #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_wb_slave_if (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_wb_cyc      (i_wb_cyc),
        .i_wb_stb      (i_wb_stb),
        .i_wb_we       (i_wb_we),
        .i_wb_word_adr (i_wb_adr[ADDRESS_WIDTH-1:2]),
        .o_wb_stall    (o_wb_stall),
        .o_wb_ack      (o_wb_ack),
        .o_rd_accept   (w_rd_accept),
        .o_wr_accept   (w_wr_accept),
        .o_index       (w_index)
    );

    // Byte lanes beyond bit 0 and the byte offset carry no state here.
    assign w_unused = ^{i_wb_adr[1:0], i_wb_sel[3:1], i_wb_dat[31:1]};

    always_comb begin
        w_rd_data = DEFAULT_READ_DATA;
        if (w_index == IW'(REG_MAGIC)) begin
            w_rd_data = MAGIC_VALUE;
        end else if (w_index == IW'(REG_CON)) begin
            w_rd_data = 32'h0;
            w_rd_data[CON_RST_BIT] = r_con_rst;
        end else if (w_index == IW'(REG_ADCSTR1)) begin
            w_rd_data = i_adcstr1_rx_data;
        end else if (w_index == IW'(REG_ADCSTR2)) begin
            w_rd_data = i_adcstr2_rx_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_con_rst <= 1'b0;
            r_dat     <= 32'h0;
        end else begin
            if (w_wr_accept && (w_index == IW'(REG_CON)) && i_wb_sel[0]) begin
                r_con_rst <= i_wb_dat[CON_RST_BIT];
            end
            if (w_rd_accept) begin
                r_dat <= w_rd_data;
            end
        end
    end

    // Pop at the same edge that captures the head word, so streaming reads
    // see consecutive FIFO entries.
    assign o_adcstr1_rx_data_read_trigger = w_rd_accept && (w_index == IW'(REG_ADCSTR1));
    assign o_adcstr2_rx_data_read_trigger = w_rd_accept && (w_index == IW'(REG_ADCSTR2));

    assign o_wb_dat  = r_dat;
    assign o_con_rst = r_con_rst;

endmodule : lwdo_regs_wb
`default_nettype wire

// File: tb/tb_lwdo_regs_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_lwdo_regs_wb
// Description : Directed self-checking bench for lwdo_regs_wb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lwdo_regs_wb;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_wb_cyc = 1'b0;
    logic        i_wb_stb = 1'b0;
    logic        i_wb_we = 1'b0;
    logic [9:0]  i_wb_adr = '0;
    logic [31:0] i_wb_dat = '0;
    logic [3:0]  i_wb_sel = '0;
    logic        o_wb_stall;
    logic        o_wb_ack;
    logic [31:0] o_wb_dat;
    logic        o_trig1;
    logic        o_trig2;
    logic        o_con_rst;

    logic [31:0] r_fifo1 = 32'hABCD0000;
    logic [31:0] r_fifo2 = 32'hEFFA0000;
    int          r_pops1 = 0;
    int          r_pops2 = 0;

    int errors = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    lwdo_regs_wb #(
        .ADDRESS_WIDTH     (10),
        .DEFAULT_READ_DATA (32'hDEADBEEF)
    ) dut (
        .i_clk                          (i_clk),
        .i_rst                          (i_rst),
        .i_wb_cyc                       (i_wb_cyc),
        .i_wb_stb                       (i_wb_stb),
        .o_wb_stall                     (o_wb_stall),
        .o_wb_ack                       (o_wb_ack),
        .i_wb_we                        (i_wb_we),
        .i_wb_adr                       (i_wb_adr),
        .i_wb_dat                       (i_wb_dat),
        .i_wb_sel                       (i_wb_sel),
        .o_wb_dat                       (o_wb_dat),
        .i_adcstr1_rx_data              (r_fifo1),
        .i_adcstr2_rx_data              (r_fifo2),
        .o_adcstr1_rx_data_read_trigger (o_trig1),
        .o_adcstr2_rx_data_read_trigger (o_trig2),
        .o_con_rst                      (o_con_rst)
    );

    // FIFO models: head advances on each pop pulse.
    always @(posedge i_clk) begin
        if (o_trig1) begin
            r_fifo1 <= r_fifo1 + 32'd1;
            r_pops1 <= r_pops1 + 1;
        end
        if (o_trig2) begin
            r_fifo2 <= r_fifo2 + 32'd1;
            r_pops2 <= r_pops2 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [9:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic chk_rd,
                           input logic [31:0] exp_rd, input string tag);
        @(negedge i_clk);
        chk({tag, "_ack_pre"}, {31'd0, o_wb_ack}, 32'd0);
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        i_wb_we  = we;
        i_wb_adr = adr;
        i_wb_dat = dat;
        i_wb_sel = sel;
        @(posedge i_clk);
        #1;
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
        chk({tag, "_ack"}, {31'd0, o_wb_ack}, 32'd1);
        if (chk_rd) chk({tag, "_dat"}, o_wb_dat, exp_rd);
        @(posedge i_clk);
        #1;
        chk({tag, "_ack_post"}, {31'd0, o_wb_ack}, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_ack", {31'd0, o_wb_ack}, 32'd0);
        chk("rst_dat", o_wb_dat, 32'd0);
        chk("rst_con", {31'd0, o_con_rst}, 32'd0);
        chk("stall", {31'd0, o_wb_stall}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // MAGIC register
        wb_xfer(1'b0, 10'h000, 32'h0, 4'hF, 1'b1, 32'h4C57444F, "magic_rd");
        wb_xfer(1'b1, 10'h000, 32'h0, 4'hF, 1'b0, 32'h0, "magic_wr");
        wb_xfer(1'b0, 10'h000, 32'h0, 4'hF, 1'b1, 32'h4C57444F, "magic_rd2");

        // CON register
        wb_xfer(1'b0, 10'h004, 32'h0, 4'hF, 1'b1, 32'h00000000, "con_rd0");
        wb_xfer(1'b1, 10'h004, 32'h1, 4'hF, 1'b0, 32'h0, "con_wr1");
        chk("con_rst_out", {31'd0, o_con_rst}, 32'd1);
        wb_xfer(1'b0, 10'h004, 32'h0, 4'h0, 1'b1, 32'h00000001, "con_rd1");
        wb_xfer(1'b1, 10'h004, 32'h0, 4'h0, 1'b0, 32'h0, "con_wr_nosel");
        wb_xfer(1'b0, 10'h004, 32'h0, 4'hF, 1'b1, 32'h00000001, "con_rd_keep");

        // ADC stream 1, single reads
        wb_xfer(1'b0, 10'h008, 32'h0, 4'hF, 1'b1, 32'hABCD0000, "s1_rd0");
        wb_xfer(1'b0, 10'h008, 32'h0, 4'hF, 1'b1, 32'hABCD0001, "s1_rd1");
        wb_xfer(1'b0, 10'h008, 32'h0, 4'hF, 1'b1, 32'hABCD0002, "s1_rd2");
        wb_xfer(1'b0, 10'h008, 32'h0, 4'hF, 1'b1, 32'hABCD0003, "s1_rd3");
        wb_xfer(1'b0, 10'h008, 32'h0, 4'hF, 1'b1, 32'hABCD0004, "s1_rd4");
        chk("s1_pops", r_pops1, 32'd5);
        chk("s1_fifo2_idle", r_pops2, 32'd0);
        wb_xfer(1'b1, 10'h008, 32'h12345678, 4'hF, 1'b0, 32'h0, "s1_wr");
        chk("s1_wr_nopop", r_pops1, 32'd5);

        // ADC stream 2, single reads
        wb_xfer(1'b0, 10'h00C, 32'h0, 4'hF, 1'b1, 32'hEFFA0000, "s2_rd0");
        wb_xfer(1'b0, 10'h00C, 32'h0, 4'hF, 1'b1, 32'hEFFA0001, "s2_rd1");
        wb_xfer(1'b0, 10'h00C, 32'h0, 4'hF, 1'b1, 32'hEFFA0002, "s2_rd2");
        wb_xfer(1'b0, 10'h00C, 32'h0, 4'hF, 1'b1, 32'hEFFA0003, "s2_rd3");
        wb_xfer(1'b0, 10'h00C, 32'h0, 4'hF, 1'b1, 32'hEFFA0004, "s2_rd4");
        chk("s2_pops", r_pops2, 32'd5);
        chk("s2_fifo1_idle", r_pops1, 32'd5);

        // ADC stream 2, back-to-back strobes
        @(negedge i_clk);
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        i_wb_we  = 1'b0;
        i_wb_adr = 10'h00C;
        @(posedge i_clk); #1;
        chk("b2b_ack0", {31'd0, o_wb_ack}, 32'd1);
        chk("b2b_dat0", o_wb_dat, 32'hEFFA0005);
        @(posedge i_clk); #1;
        chk("b2b_ack1", {31'd0, o_wb_ack}, 32'd1);
        chk("b2b_dat1", o_wb_dat, 32'hEFFA0006);
        @(posedge i_clk); #1;
        chk("b2b_dat2", o_wb_dat, 32'hEFFA0007);
        @(posedge i_clk); #1;
        chk("b2b_dat3", o_wb_dat, 32'hEFFA0008);
        @(posedge i_clk); #1;
        chk("b2b_ack4", {31'd0, o_wb_ack}, 32'd1);
        chk("b2b_dat4", o_wb_dat, 32'hEFFA0009);
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        @(posedge i_clk); #1;
        chk("b2b_ack_end", {31'd0, o_wb_ack}, 32'd0);
        chk("b2b_dat_hold", o_wb_dat, 32'hEFFA0009);
        chk("b2b_pops", r_pops2, 32'd10);

        // Unmapped index 0xFE
        wb_xfer(1'b0, 10'h3F8, 32'h0, 4'hF, 1'b1, 32'hDEADBEEF, "unmapped");
        chk("unmapped_nopop", r_pops1 + r_pops2, 32'd15);

        // Reset pulse with CON.RST=1 and a request presented during reset
        chk("pre_reset_con", {31'd0, o_con_rst}, 32'd1);
        @(negedge i_clk);
        i_rst    = 1'b1;
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        i_wb_we  = 1'b0;
        i_wb_adr = 10'h008;
        #1;
        chk("rst_trig_gated", {31'd0, o_trig1}, 32'd0);
        @(posedge i_clk); #1;
        chk("rst_pulse_ack", {31'd0, o_wb_ack}, 32'd0);
        chk("rst_pulse_con", {31'd0, o_con_rst}, 32'd0);
        chk("rst_pulse_dat", o_wb_dat, 32'd0);
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("rst_nopop", r_pops1, 32'd5);
        wb_xfer(1'b0, 10'h004, 32'h0, 4'hF, 1'b1, 32'h00000000, "con_after_rst");

        // Strobe without cycle
        @(negedge i_clk);
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b1;
        i_wb_we  = 1'b0;
        i_wb_adr = 10'h008;
        #1;
        chk("nocyc_trig1", {31'd0, o_trig1}, 32'd0);
        @(posedge i_clk); #1;
        chk("nocyc_ack", {31'd0, o_wb_ack}, 32'd0);
        i_wb_adr = 10'h00C;
        @(posedge i_clk); #1;
        chk("nocyc_ack2", {31'd0, o_wb_ack}, 32'd0);
        i_wb_stb = 1'b0;
        chk("nocyc_pops", r_pops1 + r_pops2, 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_lwdo_regs_wb
`default_nettype wire
